clock_divider_arbiter: RTL and testbench
========================================

Name: clock_divider_arbiter

Overview:
- Shares one `clock_divider` instance between NUM_REQ requesters.
- Each requester asks for a burst of divided-clock output cycles at its own divide ratio.
- Round-robin arbitration picks the next requester. The block then programs and resets the divider, enables it, and counts rising edges of the divider output in the `in_clk` domain. It releases the divider when the burst is complete or the requester withdraws.
- Sits between the PWM/timing clients and the `clock_divider`.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, divide-ratio width; matches the divider's `n_clks` width
- CNT_W, 16, burst-length counter width

Ports:
- in_clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester request level; held high until `done`
- req_ratio  input  NUM_REQ*WIDTH  packed divide ratio per requester; slice i = bits [i*WIDTH +: WIDTH]
- req_count  input  NUM_REQ*CNT_W  packed burst length (divided-clock rising edges) per requester
- grant  output  NUM_REQ  one-hot; owner of the divider
- done  output  NUM_REQ  one-cycle pulse to the owner at burst completion
- err  output  1  one-cycle pulse when a granted request has `req_ratio` == 0
- busy  output  1  high in any state other than IDLE
- div_enable  output  1  drives the divider's `enable`
- div_reset  output  1  drives the divider's `reset`
- div_n_clks  output  WIDTH  drives the divider's `n_clks`
- div_out_clk  input  1  divider's `out_clk`, synchronous to `in_clk`

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = 0, edge register = 0, counter = 0.
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE:
  - If `req` != 0, select the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Next cycle: enter LOAD with `grant` one-hot on the winner.
  - Latch `div_n_clks` = winner's ratio and target = winner's count.
  - Set the pointer to winner+1 mod NUM_REQ.
- LOAD (exactly 1 cycle):
  - `div_reset` = 1, `div_enable` = 0, counter cleared.
  - If ratio == 0: pulse `err`, go to FIN without running.
  - If target == 0: go to FIN.
  - Otherwise: go to RUN.
- RUN:
  - `div_enable` = 1, `div_reset` = 0.
  - Rising edge = `div_out_clk` & ~registered(`div_out_clk`); the edge register is cleared in LOAD.
  - Each rising edge increments the counter.
  - When counter+1 == target on an edge: go to FIN. `div_enable` drops in the FIN cycle.
- FIN (1 cycle):
  - `done`[owner] = 1 and `div_enable` = 0.
  - Next cycle: IDLE, `grant` = 0, `div_n_clks` holds its last value.
  - `err` and `done` may both fire for the same request.
- Abort:
  - If `req`[owner] deasserts in LOAD or RUN, go to IDLE next cycle.
  - `grant` = 0, `div_enable` = 0, no `done` pulse, and the pointer is unchanged from the grant update.
- Simultaneous events:
  - A new request arriving during LOAD, RUN or FIN is ignored until IDLE.
  - Abort and final edge in the same cycle: abort wins.
- Minimum grant-to-grant spacing: 1 idle cycle; each grant uses IDLE→LOAD→…→FIN→IDLE.
- Counter width is CNT_W. The target is at most 2^CNT_W−1, so there is no wrap-around.
- Reset asserted mid-burst returns everything to reset values on the next edge.

Decomposition:
- Package `clkdiv_arb_pkg`:
  - FSM state enum (IDLE, LOAD, RUN, FIN)
  - Default WIDTH and CNT_W constants
- One natural sub-module: `rr_arbiter`
  - Inputs: req vector and pointer.
  - Output: one-hot winner plus valid flag.
  - Purely combinational priority rotate.

Test Plan:
- Single request: `req`=4'b0001, ratio=4, count=3, bench divider model → `grant`=0001 from cycle 1, `div_reset` high 1 cycle, `done`[0] pulse after the 3rd `div_out_clk` rise, `busy` low the cycle after.
- Round-robin: `req`=4'b1111 held, each re-asserted after `done` → grant order 0,1,2,3,0; pointer wraps.
- Zero cases:
  - ratio=0, count=5 → `err` pulse in LOAD, `done` pulse, `div_enable` never high.
  - ratio=2, count=0 → `done` after LOAD with no enable.
- Abort: `req`[2] dropped after 2 of 10 edges → `div_enable`=0 and `grant`=0 the next cycle, no `done`. A pending `req`[3] is granted next.
- Reset mid-RUN: assert `reset` for 1 cycle during RUN → all outputs 0 the next cycle. Pointer = 0, so with `req`=1010 granted again, index 1 wins.
- Simultaneous abort and final edge: drop `req` on the cycle the count is reached → no `done` pulse.

Source files
------------

// File: rtl/clkdiv_arb_pkg.sv
// Shared types and default widths for the clock-divider arbiter.
package clkdiv_arb_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority pick: first set request at or after the pointer,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx,
    output logic               valid
);

    logic [PTR_W-1:0] cand;

    // Walk the requests starting at the pointer; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_divider_arbiter.sv
// Shares one clock_divider between NUM_REQ requesters. Each grant programs
// and resets the divider, runs it for a burst of divided-clock rising edges,
// then releases it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | divider free; round-robin pick among pending requests
// LOAD  | divider held in reset, counter and edge register cleared
// RUN   | divider enabled, counting rising edges of div_out_clk
// FIN   | burst complete; done pulse to owner, divider disabled
module clock_divider_arbiter
    import clkdiv_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                     in_clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_ratio,
    input  logic [NUM_REQ*CNT_W-1:0] req_count,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     err,
    output logic                     busy,
    output logic                     div_enable,
    output logic                     div_reset,
    output logic [WIDTH-1:0]         div_n_clks,
    input  logic                     div_out_clk
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [NUM_REQ-1:0] grant_q;
    logic [CNT_W-1:0]   target;
    logic [CNT_W-1:0]   count;
    logic               edge_q;
    logic               rise;
    logic               owner_req;
    logic               final_edge;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_valid;

    logic [WIDTH-1:0]   ratio_arr [NUM_REQ];
    logic [CNT_W-1:0]   count_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign ratio_arr[g] = req_ratio[g*WIDTH +: WIDTH];
        assign count_arr[g] = req_count[g*CNT_W +: CNT_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign grant      = grant_q;
    assign rise       = div_out_clk & ~edge_q;
    assign owner_req  = |(req & grant_q);
    // Compare one bit wider so a target of all-ones cannot alias to zero.
    assign final_edge = rise &&
                        (({1'b0, count} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, target});

    // State register.
    always_ff @(posedge in_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and divider control; owner withdrawal overrides every other
    // exit from LOAD and RUN, including a coincident final edge.
    always_comb begin
        state_nxt  = state;
        done       = '0;
        err        = 1'b0;
        div_enable = 1'b0;
        div_reset  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (arb_valid) state_nxt = LOAD;
            end
            LOAD: begin
                div_reset = 1'b1;
                err       = (div_n_clks == '0);
                if (!owner_req)                                  state_nxt = IDLE;
                else if ((div_n_clks == '0) || (target == '0))   state_nxt = FIN;
                else                                             state_nxt = RUN;
            end
            RUN: begin
                div_enable = 1'b1;
                if (!owner_req)      state_nxt = IDLE;
                else if (final_edge) state_nxt = FIN;
            end
            FIN: begin
                done      = grant_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant latch, round-robin pointer, burst counter and edge register.
    always_ff @(posedge in_clk) begin
        if (reset) begin
            ptr        <= '0;
            grant_q    <= '0;
            div_n_clks <= '0;
            target     <= '0;
            count      <= '0;
            edge_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant_q    <= arb_gnt;
                        div_n_clks <= ratio_arr[arb_idx];
                        target     <= count_arr[arb_idx];
                        ptr        <= (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    end
                end
                LOAD: begin
                    count  <= '0;
                    edge_q <= 1'b0;
                end
                RUN: begin
                    edge_q <= div_out_clk;
                    if (rise) count <= count + 1'b1;
                end
                default: ;
            endcase
            if ((state != IDLE) && (state_nxt == IDLE)) grant_q <= '0;
        end
    end

endmodule

// File: tb/tb_clock_divider_arbiter.sv
// Directed bench for clock_divider_arbiter with a behavioural divider model.
// Expected grants and burst completions are queued as stimulus is applied
// and checked by a negedge monitor as the DUT produces them.
module tb_clock_divider_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int CW = 16;

    typedef struct {
        int ex_idx;
        int ex_rises;
        bit ex_en;
        bit ex_err;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   req;
    logic [NR*W-1:0] req_ratio;
    logic [NR*CW-1:0] req_count;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   done;
    logic            err;
    logic            busy;
    logic            div_enable;
    logic            div_reset;
    logic [W-1:0]    div_n_clks;
    logic            div_out_clk;

    int checks = 0;
    int errors = 0;

    int   gq[$];
    exp_t dq[$];

    int       mon_rises = 0;
    bit       en_seen   = 0;
    bit       err_seen  = 0;
    bit       after_load = 0;
    int       err_total = 0;
    logic     prev_out  = 1'b0;
    logic [NR-1:0] prev_grant = '0;

    logic [W-1:0] mcnt;
    logic         mout;

    clock_divider_arbiter #(
        .NUM_REQ (NR),
        .WIDTH   (W),
        .CNT_W   (CW)
    ) dut (
        .in_clk      (clk),
        .reset       (reset),
        .req         (req),
        .req_ratio   (req_ratio),
        .req_count   (req_count),
        .grant       (grant),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .div_enable  (div_enable),
        .div_reset   (div_reset),
        .div_n_clks  (div_n_clks),
        .div_out_clk (div_out_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: output toggles every n_clks enabled cycles.
    always @(posedge clk) begin
        if (reset || div_reset) begin
            mcnt <= '0;
            mout <= 1'b0;
        end else if (div_enable) begin
            if (mcnt == div_n_clks - 1) begin
                mcnt <= '0;
                mout <= ~mout;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end
    assign div_out_clk = mout;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic cfg(input int i, input logic [W-1:0] r, input logic [CW-1:0] c);
        req_ratio[i*W +: W]   = r;
        req_count[i*CW +: CW] = c;
    endtask

    task automatic push_exp(input int idx, input int rises, input bit en, input bit er);
        exp_t e;
        e.ex_idx   = idx;
        e.ex_rises = rises;
        e.ex_en    = en;
        e.ex_err   = er;
        dq.push_back(e);
    endtask

    task automatic wait_done(input int idx, input int budget);
        int n;
        n = 0;
        while (done[idx] !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk($sformatf("done_wait_%0d", idx), {63'd0, done[idx]}, 64'd1);
    endtask

    task automatic wait_rises(input int target, input int budget);
        int n;
        n = 0;
        while (mon_rises < target && n < budget) begin
            step();
            n++;
        end
        chk("rises_wait", mon_rises, target);
    endtask

    // Scoreboard monitor: grants, divider edges and done pulses.
    always @(negedge clk) begin
        logic [NR-1:0] oh;
        int   gi;
        exp_t e;
        if (reset) begin
            prev_grant = '0;
            after_load = 0;
        end else begin
            if (grant != '0 && prev_grant == '0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", grant, 0);
                end else begin
                    gi = gq.pop_front();
                    oh = '0;
                    oh[gi] = 1'b1;
                    chk("grant_order", grant, oh);
                end
                chk("load_div_reset", div_reset, 1);
                chk("load_div_enable", div_enable, 0);
                mon_rises  = 0;
                en_seen    = 0;
                err_seen   = 0;
                after_load = 1;
            end else if (busy) begin
                if (after_load) begin
                    chk("div_reset_one_cycle", div_reset, 0);
                    after_load = 0;
                end
                if (div_out_clk && !prev_out) mon_rises++;
            end
            if (div_enable) en_seen = 1;
            if (err) begin
                err_seen = 1;
                err_total++;
            end
            if (done != '0) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    e  = dq.pop_front();
                    oh = '0;
                    oh[e.ex_idx] = 1'b1;
                    chk("done_owner", done, oh);
                    chk("done_rises", mon_rises, e.ex_rises);
                    chk("done_enable_seen", {63'd0, en_seen}, {63'd0, e.ex_en});
                    chk("done_err_seen", {63'd0, err_seen}, {63'd0, e.ex_err});
                end
            end
            prev_grant = grant;
        end
        prev_out = div_out_clk;
    end

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_ratio = '0;
        req_count = '0;
        step(); step(); step();
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div_enable", div_enable, 0);
        chk("rst_div_reset", div_reset, 0);
        chk("rst_div_n_clks", div_n_clks, 0);
        reset = 1'b0;

        // Single request, ratio 4, three edges.
        cfg(0, 4, 3);
        gq.push_back(0);
        push_exp(0, 3, 1'b1, 1'b0);
        req = 4'b0001;
        step();
        chk("t1_grant", grant, 4'b0001);
        chk("t1_n_clks", div_n_clks, 4);
        chk("t1_busy", busy, 1);
        wait_done(0, 200);
        req = '0;
        step();
        chk("t1_busy_after", busy, 0);
        chk("t1_grant_after", grant, 0);
        chk("t1_n_clks_hold", div_n_clks, 4);

        // Round-robin from a fresh pointer: 0,1,2,3,0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) cfg(i, 2, 2);
        gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
        push_exp(0, 2, 1'b1, 1'b0);
        push_exp(1, 2, 1'b1, 1'b0);
        push_exp(2, 2, 1'b1, 1'b0);
        push_exp(3, 2, 1'b1, 1'b0);
        push_exp(0, 2, 1'b1, 1'b0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(k % NR, 200);
            if (k == 4) req = '0;
            else        req[k % NR] = 1'b0;
            step();
            if (k < 4) req[k % NR] = 1'b1;
        end
        chk("t2_idle", busy, 0);

        // Zero ratio: err in LOAD, done, never enabled.
        cfg(1, 0, 5);
        gq.push_back(1);
        push_exp(1, 0, 1'b0, 1'b1);
        req = 4'b0010;
        step();
        chk("t3_err_in_load", err, 1);
        chk("t3_div_reset", div_reset, 1);
        wait_done(1, 10);
        req = '0;
        step();
        chk("t3_busy_after", busy, 0);

        // Zero count: done right after LOAD, never enabled.
        cfg(2, 2, 0);
        gq.push_back(2);
        push_exp(2, 0, 1'b0, 1'b0);
        req = 4'b0100;
        wait_done(2, 10);
        req = '0;
        step();
        chk("t4_busy_after", busy, 0);

        // Abort requester 2 after two edges; pending requester 3 goes next.
        cfg(2, 2, 10);
        cfg(3, 1, 2);
        gq.push_back(2);
        req = 4'b0100;
        step();
        chk("t5_grant", grant, 4'b0100);
        req[3] = 1'b1;
        wait_rises(2, 200);
        req[2] = 1'b0;
        step();
        chk("t5_abort_grant", grant, 0);
        chk("t5_abort_enable", div_enable, 0);
        chk("t5_abort_done", done, 0);
        gq.push_back(3);
        push_exp(3, 2, 1'b1, 1'b0);
        wait_done(3, 200);
        req = '0;
        step();

        // Reset in the middle of a burst.
        cfg(1, 3, 4);
        gq.push_back(1);
        req = 4'b0010;
        step();
        repeat (10) step();
        chk("t6_running", div_enable, 1);
        reset = 1'b1;
        step();
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_enable", div_enable, 0);
        chk("t6_rst_div_reset", div_reset, 0);
        chk("t6_rst_n_clks", div_n_clks, 0);
        chk("t6_rst_done", done, 0);
        reset = 1'b0;
        req   = 4'b1010;
        gq.push_back(1);
        push_exp(1, 4, 1'b1, 1'b0);
        wait_done(1, 300);
        req = '0;
        step();

        // Withdrawal on the cycle the final edge is seen: no done.
        cfg(0, 2, 2);
        gq.push_back(0);
        req = 4'b0001;
        step();
        wait_rises(2, 200);
        req = '0;
        step();
        chk("t7_grant", grant, 0);
        chk("t7_done", done, 0);
        chk("t7_busy", busy, 0);
        step();
        chk("t7_done_later", done, 0);

        repeat (5) step();
        chk("done_queue_empty", dq.size(), 0);
        chk("grant_queue_empty", gq.size(), 0);
        chk("err_pulse_total", err_total, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
